// File: rtl/jk_bank_ctrl.sv
// Sequencing controller for a bank of JK flops: clear/set/load/toggle/count
// commands over valid/ready, driving J/K from latched command state and live Q.
package jk_bank_ctrl_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_TOGL  = 3'd4;
  localparam logic [2:0] OP_UP    = 3'd5;
  localparam logic [2:0] OP_DN    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;
endpackage

// One bit of J/K drive; carry/borrow say whether all lower Q bits are 1/0.
module jk_bank_ctrl_lane
  import jk_bank_ctrl_pkg::*;
(
  input  logic       en,
  input  logic [2:0] op,
  input  logic       data,
  input  logic       up_carry,
  input  logic       dn_borrow,
  output logic       j,
  output logic       k
);
  always_comb begin
    j = 1'b0;
    k = 1'b0;
    if (en) begin
      case (op)
        OP_CLEAR: k = 1'b1;
        OP_SET:   j = 1'b1;
        OP_LOAD:  begin j = data;      k = ~data;     end
        OP_TOGL:  begin j = data;      k = data;      end
        OP_UP:    begin j = up_carry;  k = up_carry;  end
        OP_DN:    begin j = dn_borrow; k = dn_borrow; end
        default:  ;
      endcase
    end
  end
endmodule

module jk_bank_ctrl
  import jk_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] remaining;
  logic             abort_flag;
  logic             accept, is_cnt, step_en;
  logic [2:0]       acc_op;
  logic [CNT_W-1:0] acc_cnt;
  logic [WIDTH:0]   up_carry, dn_borrow;

  assign accept = cmd_valid_i && cmd_ready_o;
  assign is_cnt = (cmd_op_i == OP_UP) || (cmd_op_i == OP_DN);
  // A zero-length count still takes one step, but as a no-change NOP step.
  assign acc_op  = (is_cnt && cmd_count_i == '0) ? OP_NOP : cmd_op_i;
  assign acc_cnt = (is_cnt && cmd_count_i != '0) ? cmd_count_i : CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cmd_q      <= '{op: OP_NOP, data: '0};
      remaining  <= '0;
      abort_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          cmd_q      <= '{op: acc_op, data: cmd_data_i};
          remaining  <= acc_cnt;
          abort_flag <= 1'b0;
        end
        S_STEP: begin
          if (abort_i)                       abort_flag <= 1'b1;
          else if (remaining != CNT_W'(1))   remaining  <= remaining - CNT_W'(1);
        end
        default: abort_flag <= 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_STEP;
      S_STEP:  if (abort_i || remaining == CNT_W'(1)) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = reset && (state == S_IDLE);
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
    aborted_o   = (state == S_DONE) && abort_flag;
    step_en     = (state == S_STEP) && !abort_i;
  end

  // Ripple prefix over live Q: carry chain for up-count, borrow chain for down.
  assign up_carry[0]  = 1'b1;
  assign dn_borrow[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign up_carry[i+1]  = up_carry[i]  &  q_i[i];
    assign dn_borrow[i+1] = dn_borrow[i] & ~q_i[i];

    jk_bank_ctrl_lane u_lane (
      .en       (step_en),
      .op       (cmd_q.op),
      .data     (cmd_q.data[i]),
      .up_carry (up_carry[i]),
      .dn_borrow(dn_borrow[i]),
      .j        (j_o[i]),
      .k        (k_o[i])
    );
  end
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: behavioural JK bank as the plant, arithmetic model
// of the register value, directed plan steps followed by random commands.
module tb_jk_bank_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready_o;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] j_o, k_o;
  logic             busy_o, done_o, aborted_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [WIDTH-1:0] model_q = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Plant: WIDTH independent JK flops sharing clk and reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) bank_q <= '0;
    else for (int i = 0; i < WIDTH; i++)
      case ({j_o[i], k_o[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: ;
      endcase
  end

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready_o),
    .cmd_op_i   (cmd_op),
    .cmd_data_i (cmd_data),
    .cmd_count_i(cmd_count),
    .abort_i    (abort),
    .q_i        (bank_q),
    .j_o        (j_o),
    .k_o        (k_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register value after one committed step, from the command's meaning.
  function automatic logic [WIDTH-1:0] step_model(input logic [2:0] op,
      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] q, input bit zero_cnt);
    case (op)
      3'd1:    return '0;
      3'd2:    return '1;
      3'd3:    return d;
      3'd4:    return q ^ d;
      3'd5:    return zero_cnt ? q : q + WIDTH'(1);
      3'd6:    return zero_cnt ? q : q - WIDTH'(1);
      default: return q;
    endcase
  endfunction

  // abort_step s (1..n) raises abort in the cycle before step edge s.
  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] d,
      input logic [CNT_W-1:0] cnt, input int abort_step, input bit hold_valid);
    int n, w, acc, done_at;
    bit zc, cnt_op, ab;
    cnt_op = (op == 3'd5) || (op == 3'd6);
    zc = cnt_op && (cnt == 0);
    n  = (cnt_op && cnt != 0) ? int'(cnt) : 1;
    w = 0;
    while (cmd_ready_o !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    check("ready_before_cmd", cmd_ready_o, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_count = cnt;
    @(posedge clk); #1;
    acc = cyc;
    check("busy_after_accept", busy_o, 1);
    check("ready_low_in_step", cmd_ready_o, 0);
    if (hold_valid) begin
      cmd_op = 3'($urandom_range(0, 7)); cmd_data = WIDTH'($urandom); cmd_count = CNT_W'($urandom);
    end else cmd_valid = 1'b0;
    ab = 1'b0;
    done_at = n;
    for (int s = 1; s <= n; s++) begin
      if (s == abort_step) abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      if (s == abort_step) begin
        ab = 1'b1; done_at = s;
        check("q_frozen_on_abort", bank_q, model_q);
        break;
      end
      model_q = step_model(op, d, model_q, zc);
      check($sformatf("q_step%0d_op%0d", s, op), bank_q, model_q);
      check($sformatf("done_step%0d", s), done_o, (s == n) ? 1 : 0);
    end
    check("done_pulse", done_o, 1);
    check("aborted_flag", aborted_o, ab);
    check("ready_low_in_done", cmd_ready_o, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("done_one_cycle", done_o, 0);
    check("ready_after_done", cmd_ready_o, 1);
    check("busy_cleared", busy_o, 0);
    check("q_unchanged_after", bank_q, model_q);
    check("cmd_latency", cyc - acc, done_at + 1);
  endtask

  initial begin
    int n, ab_s;
    logic [2:0] op;
    logic [CNT_W-1:0] c;
    #2;
    check("rst_ready", cmd_ready_o, 0);
    check("rst_j", j_o, 0);
    check("rst_k", k_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_aborted", aborted_o, 0);
    check("rst_q", bank_q, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", cmd_ready_o, 1);

    run_cmd(3'd3, 4'b1010, 8'd0, 0, 1'b0);
    run_cmd(3'd3, 4'b1101, 8'd0, 0, 1'b0);
    run_cmd(3'd5, 4'b0000, 8'd5, 0, 1'b0);
    check("up5_result", bank_q, 4'b0010);
    run_cmd(3'd3, 4'b0001, 8'd0, 0, 1'b0);
    run_cmd(3'd6, 4'b0000, 8'd3, 0, 1'b0);
    check("dn3_result", bank_q, 4'b1110);
    run_cmd(3'd3, 4'b1010, 8'd0, 0, 1'b0);
    run_cmd(3'd4, 4'b0110, 8'd0, 0, 1'b0);
    check("toggle_result", bank_q, 4'b1100);
    run_cmd(3'd1, 4'b0000, 8'd0, 0, 1'b1);
    run_cmd(3'd2, 4'b0000, 8'd0, 0, 1'b1);
    check("set_all_result", bank_q, 4'b1111);
    run_cmd(3'd1, 4'b0000, 8'd0, 0, 1'b0);
    run_cmd(3'd5, 4'b0000, 8'd10, 4, 1'b0);
    check("abort_freeze", bank_q, 4'b0011);
    run_cmd(3'd3, 4'b0101, 8'd0, 0, 1'b0);
    run_cmd(3'd5, 4'b0000, 8'd2, 2, 1'b0);
    run_cmd(3'd7, 4'b1111, 8'd3, 0, 1'b0);
    run_cmd(3'd6, 4'b0000, 8'd0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      op = 3'($urandom_range(0, 7));
      c  = CNT_W'($urandom_range(0, 6));
      n  = ((op == 3'd5 || op == 3'd6) && c != 0) ? int'(c) : 1;
      ab_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      run_cmd(op, WIDTH'($urandom), c, ab_s, 1'($urandom_range(0, 1)));
    end

    // Count of zero, then reset in the middle of a longer count.
    run_cmd(3'd5, 4'b0000, 8'd0, 0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_count = 8'd8; cmd_data = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      @(posedge clk); #1;
      model_q = model_q + WIDTH'(1);
      check("pre_reset_q", bank_q, model_q);
    end
    reset = 1'b0;
    #1;
    check("midrst_j", j_o, 0);
    check("midrst_k", k_o, 0);
    check("midrst_q", bank_q, 0);
    check("midrst_ready", cmd_ready_o, 0);
    check("midrst_busy", busy_o, 0);
    model_q = '0;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      check("midrst_no_done", done_o, 0);
      check("midrst_ready_held", cmd_ready_o, 0);
    end
    @(negedge clk); reset = 1'b1;
    #1;
    check("ready_after_midrst", cmd_ready_o, 1);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", done_o, 0);
    end
    run_cmd(3'd3, 4'b0110, 8'd0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Sequencing controller for a bank of WIDTH `jk_ff` flip-flops that together form a WIDTH-bit register. The controller accepts one command at a time over a valid/ready handshake. It drives each flop's J and K inputs and reads the flops' Q outputs back, so it can clear, set, load, toggle, or count the register up or down for a programmed number of clock steps. It sits between the command source and the flop bank and is the only driver of the bank's J/K pins. The bank and the controller share `clk`.

## Interface
- WIDTH, 4, number of JK flops in the bank
- CNT_W, 8, width of the step-count field

- clk  input  1  single clock; the controller and the flop bank both update on the rising edge
- reset  input  1  asynchronous, active-low; also wired to the flop bank's reset
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  controller can accept a command
- cmd_op_i  input  3  opcode: 0 NOP, 1 CLEAR, 2 SET_ALL, 3 LOAD, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 reserved (treated as NOP)
- cmd_data_i  input  WIDTH  load value (LOAD) or toggle mask (TOGGLE)
- cmd_count_i  input  CNT_W  number of steps for CNT_UP and CNT_DN
- abort_i  input  1  terminate the current command
- q_i  input  WIDTH  Q feedback from the flop bank
- j_o, k_o  output  WIDTH each  J/K drive to the flop bank
- busy_o  output  1  a command is in progress (STEP or DONE state)
- done_o  output  1  one-cycle completion pulse
- aborted_o  output  1  qualifies done_o; high when the command ended on abort

## Operation
- FSM states: IDLE, STEP, DONE. Encoding is free.
- IDLE
  - cmd_ready_o=1, j_o=k_o=0.
  - Handshake: a command is accepted at the rising edge where cmd_valid_i and cmd_ready_o are both 1.
  - On acceptance: latch op, data and step count into registers, then go to STEP.
  - Single-step ops (NOP, CLEAR, SET_ALL, LOAD, TOGGLE, reserved) load a step count of 1.
  - CNT_UP and CNT_DN load cmd_count_i. A count of 0 is replaced by 1 step with j=k=0 (no register change).
- STEP: j_o/k_o are combinational from the latched op/data and the live q_i.
  - NOP / reserved: j=0, k=0.
  - CLEAR: j=0, k=all-ones.
  - SET_ALL: j=all-ones, k=0.
  - LOAD: j=data, k=~data.
  - TOGGLE: j=k=mask.
  - CNT_UP: j[i]=k[i]=1 when q_i[0..i-1] are all 1. Bit 0 always toggles.
  - CNT_DN: j[i]=k[i]=1 when q_i[0..i-1] are all 0. Bit 0 always toggles.
  - Each rising edge spent in STEP commits exactly one step in the flops.
  - At each edge: if remaining==1, go to DONE; otherwise decrement remaining.
- Wrap-around is modular, produced by the JK toggle chain:
  - CNT_UP from all-ones gives 0.
  - CNT_DN from 0 gives all-ones.
- Abort: abort_i high during STEP forces j_o=k_o=0 combinationally in that same cycle, so no flop changes at the next edge. The next state is DONE with the abort flag set. abort_i is ignored in IDLE and DONE.
- DONE: j_o=k_o=0, done_o=1, aborted_o=flag, cmd_ready_o=0. Next state is always IDLE, and the flag clears.
- Reset low (asynchronous):
  - state=IDLE, remaining=0, abort flag=0, latched op=NOP.
  - Because the flop bank is reset at the same time, j_o=k_o=0 immediately.
  - cmd_ready_o is forced to 0 while reset is low.

## Timing
- Reset values: cmd_ready_o=0 while reset is asserted, then 1 from the first cycle after release. All other outputs are 0.
- Command accepted at edge E0: STEP occupies cycles E0..En and steps commit at E1..En. done_o is high during cycle En..En+1. cmd_ready_o returns to 1 after En+1.
- Back-to-back throughput: n+2 cycles per command, where n = step count.
- q_i must be the bank's registered Q, with no combinational path from j_o into q_i.
- Abort seen in the cycle before a step edge: that step is not committed, and done_o follows one cycle later.
- Abort on the final step cycle: abort wins, the last step is not committed, and aborted_o=1.
- Reset mid-STEP: the FSM returns to IDLE and no done_o pulse is produced.
- cmd_valid_i during STEP or DONE has no effect. The command is held off by cmd_ready_o=0.

## Test plan
- Reset, then LOAD with data=4'b1010: bank Q=1010 at E1; done_o high for exactly one cycle; ready again 2 cycles after acceptance.
- CNT_UP with count=5 from Q=1101: Q sequence 1110, 1111, 0000, 0001, 0010; done_o after the 5th edge; aborted_o=0.
- CNT_DN with count=3 from Q=0001: Q sequence 0000, 1111, 1110.
- TOGGLE mask=0110 on 1010, then CLEAR, then SET_ALL issued back-to-back: Q goes 1100, then 0000, then 1111; each command takes 3 cycles.
- CNT_UP with count=10 from 0000, abort_i asserted on step 4: Q freezes at 0011; done_o=1 with aborted_o=1; next command accepted normally.
- CNT_UP with count=0, then reset pulsed low mid-way through a count=8 CNT_UP: the count=0 command yields one no-change step plus done. During reset j_o=k_o=0 and Q=0000 immediately, cmd_ready_o=0, and no done_o pulse.
